// File: rtl/latch_sched_pkg.sv
// Shared definitions for the write-bank scheduler: sequencer state encoding and default sizes.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning from ptr_i upward, wrapping.
// Zero latency; no backpressure, vld_o simply reports whether any request was present.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  always_comb begin
    logic [PW-1:0] c;
    logic          found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = PW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        idx_o    = c;
        gnt_o[c] = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/latch_bank_scheduler.sv
// Round-robin shared write port into a DEPTH x DW register bank with setup/strobe/recover sequencing.
// gnt two cycles after capture, one write per four cycles; requesters hold req until gnt, reads are free-running.
module latch_bank_scheduler
  import latch_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] wr_addr_i,
  input  logic [NREQ*DW-1:0] wr_data_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               busy_o,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [DW-1:0]      rd_data_o
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [PW-1:0]   w_q, w_d;
  logic [NREQ-1:0] woh_q, woh_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we;
  logic [DW-1:0]   bank_q [DEPTH];

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    w_d     = w_q;
    woh_d   = woh_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Inputs are only looked at here; anything changing afterwards cannot disturb the write.
        if (arb_vld) begin
          addr_d  = wr_addr_i[int'(arb_idx)*AW +: AW];
          data_d  = wr_data_i[int'(arb_idx)*DW +: DW];
          w_d     = arb_idx;
          woh_d   = arb_gnt;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        we      = 1'b1;
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        ptr_d   = (w_q == PW'(NREQ - 1)) ? '0 : w_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      w_q     <= '0;
      woh_q   <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      w_q     <= w_d;
      woh_q   <= woh_d;
      ptr_q   <= ptr_d;
      if (we) bank_q[addr_q] <= data_q;
    end
  end

  assign gnt_o     = (state_q == S_STROBE) ? woh_q : '0;
  assign busy_o    = (state_q != S_IDLE);
  assign rd_data_o = bank_q[rd_addr_i];

endmodule

// File: tb/tb_latch_bank_scheduler.sv
// Randomized bench with a transaction-level model and a grant scoreboard checked by a negedge monitor.
module tb_latch_bank_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] wr_addr = '0;
  logic [NREQ*DW-1:0] wr_data = '0;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [AW-1:0]      rd_addr = '0;
  logic [DW-1:0]      rd_data;

  latch_bank_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .gnt_o     (gnt),
    .busy_o    (busy),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [NREQ-1:0] oh; } exp_t;
  typedef struct { int edge_n; int addr; logic [DW-1:0] data; } wr_t;

  exp_t        sbq[$];
  wr_t         pend[$];
  logic [DW-1:0] mbank [1<<AW];
  int cyc = 0;
  int free_edge = 0;
  int ptr_m = 0;
  int busy_lo = 0;
  int busy_hi = -1;
  int captured = -1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: one write occupies the port for four edges; gnt shows in the second cycle after capture.
  task automatic model_edge();
    captured = -1;
    if (rst) begin
      for (int i = 0; i < (1<<AW); i++) mbank[i] = '0;
      ptr_m     = 0;
      free_edge = cyc + 1;
      busy_lo   = 0;
      busy_hi   = -1;
      for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].cyc >= cyc) sbq.delete(i);
      pend.delete();
      chk_en = 1'b1;
    end else begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].edge_n == cyc) begin
          mbank[pend[i].addr] = pend[i].data;
          pend.delete(i);
        end
      end
      if (cyc >= free_edge && req != '0) begin
        int w;
        exp_t e;
        wr_t  p;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
        e.cyc = cyc + 1;
        e.oh  = NREQ'(1) << w;
        sbq.push_back(e);
        p.edge_n = cyc + 2;
        p.addr   = int'(wr_addr[w*AW +: AW]);
        p.data   = wr_data[w*DW +: DW];
        pend.push_back(p);
        busy_lo   = cyc;
        busy_hi   = cyc + 2;
        free_edge = cyc + 4;
        ptr_m     = (w + 1) % NREQ;
        captured  = w;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic drive_rand(input logic [NREQ-1:0] mask, input bit hold);
    for (int i = 0; i < NREQ; i++) begin
      if (captured == i) begin
        wr_data[i*DW +: DW] = DW'($urandom);
        if (!mask[i] || (!hold && $urandom_range(1, 0) == 1)) req[i] = 1'b0;
      end else if (!req[i] && mask[i] && (hold || $urandom_range(3, 0) == 0)) begin
        req[i] = 1'b1;
        wr_addr[i*AW +: AW] = AW'($urandom);
        wr_data[i*DW +: DW] = DW'($urandom);
      end
    end
    rd_addr = AW'($urandom);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_busy;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      checks++;
      if (rd_data !== mbank[rd_addr]) begin
        errors++;
        $display("FAIL rd_data cyc=%0d addr=%0d got=%h exp=%h", cyc, rd_addr, rd_data, mbank[rd_addr]);
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL gnt_missing cyc=%0d got=none exp=%b", sbq[0].cyc, sbq[0].oh);
        void'(sbq.pop_front());
      end
      checks++;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        if (gnt !== sbq[0].oh) begin
          errors++;
          $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, sbq[0].oh);
        end
        void'(sbq.pop_front());
      end else if (gnt !== '0) begin
        errors++;
        $display("FAIL gnt_unexpected cyc=%0d got=%b exp=0000", cyc, gnt);
      end
    end
  end

  initial begin
    // Reset, then a quiet period sweeping every read address.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_addr = AW'(i);
      step();
    end

    // Abort a write with reset while it sits in SETUP.
    req = 4'b0001;
    wr_addr[0*AW +: AW] = 2'd1;
    wr_data[0*DW +: DW] = 8'h3C;
    rd_addr = 2'd1;
    step();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Single write from requester 1, then a late change on requester 0.
    req = 4'b0010;
    wr_addr[1*AW +: AW] = 2'd2;
    wr_data[1*DW +: DW] = 8'hA5;
    rd_addr = 2'd2;
    step();
    req = '0;
    for (int i = 0; i < 6; i++) step();
    req = 4'b0001;
    wr_addr[0*AW +: AW] = 2'd3;
    wr_data[0*DW +: DW] = 8'h11;
    rd_addr = 2'd3;
    step();
    wr_data[0*DW +: DW] = 8'h22;
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Fairness from a fresh pointer with every requester held high.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) wr_addr[i*AW +: AW] = AW'(i);
    for (int i = 0; i < 120; i++) begin
      step();
      drive_rand(4'b1111, 1'b1);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      drive_rand(4'b0000, 1'b0);
    end

    // Two contenders held continuously, then fully random traffic.
    for (int i = 0; i < 120; i++) begin
      step();
      drive_rand(4'b0101, 1'b1);
    end
    for (int i = 0; i < 400; i++) begin
      step();
      drive_rand(4'b1111, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      drive_rand(4'b0000, 1'b0);
    end
    req = '0;
    for (int i = 0; i < 8; i++) step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d outstanding exp=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
